fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-002 SHALL have parameter PC_W, default 32, PC-plus-4 width carried with each instruction.
REQ-003 SHALL have parameter DEPTH, default 4, entry count; power of two, minimum 2.
REQ-004 SHALL have port clk, input, 1, single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port flush, input, 1, discards all queued entries on branch, jump or jr redirect.
REQ-007 SHALL have port push_valid, input, 1, the instruction memory offers an entry.
REQ-008 SHALL have port push_ready, output, 1, the queue can accept an entry.
REQ-009 SHALL have port push_instr, input, DATA_W, fetched instruction.
REQ-010 SHALL have port push_pc4, input, PC_W, PC-plus-4 of the fetched instruction.
REQ-011 SHALL have port pop_valid, output, 1, the head entry is valid.
REQ-012 SHALL have port pop_ready, input, 1, the IF/ID stage takes the head entry; low means stall.
REQ-013 SHALL have port pop_instr, output, DATA_W, head instruction.
REQ-014 SHALL have port pop_pc4, output, PC_W, head PC-plus-4.
REQ-015 SHALL have port count, output, $clog2(DEPTH+1), current occupancy.

Function
REQ-016 SHALL accept a push when push_valid and push_ready are both high, and perform a pop when pop_valid and pop_ready are both high.
REQ-017 SHALL drive push_ready as (count < DEPTH), registered only; there SHALL be no pass-through when full, even if a pop occurs in the same cycle.
REQ-018 SHALL drive pop_valid as (count > 0) and present the head entry on pop_instr and pop_pc4 without a clock delay.
REQ-019 SHALL present a pushed entry at the head one cycle after acceptance when the queue was empty (1-cycle latency).
REQ-020 SHALL keep count unchanged, advance both pointers, and preserve order on a simultaneous push and pop.
REQ-021 SHALL wrap the read and write pointers modulo DEPTH, with no gaps or duplicates across the wrap.
REQ-022 SHALL, on flush, set count and both pointers to 0 at the next edge.
REQ-023 SHALL discard a push offered in the same cycle as flush.
REQ-024 SHALL still complete a pop in the flush cycle, so the head data is valid that cycle.
REQ-025 SHALL ignore pop_ready when empty and ignore push_valid when full; neither case changes state.
REQ-026 SHALL hold pop_instr and pop_pc4 stable while pop_valid is high and pop_ready is low.

Reset
REQ-027 SHALL, on rst_n low, immediately clear count, the read pointer and the write pointer, set push_ready to 1 and pop_valid to 0.
REQ-028 SHALL drive pop_instr and pop_pc4 to 0 while the queue is empty after reset; storage contents need not be cleared.
REQ-029 SHALL abandon any in-flight push or pop on reset mid-operation; the first edge after rst_n rises SHALL behave as an empty queue.

Configuration
REQ-030 SHALL support the macro FETCH_QUEUE_BYPASS_EN; when defined, an empty queue with push_valid high and flush low SHALL raise pop_valid combinationally and forward push_instr and push_pc4 (0-cycle latency).
REQ-031 SHALL, when FETCH_QUEUE_BYPASS_EN is defined and the bypass entry is taken that cycle, not store the entry and leave count unchanged; if pop_ready is low, it SHALL store the entry normally.
REQ-032 SHALL, when FETCH_QUEUE_BYPASS_EN is undefined, keep pop_valid purely registered, with the latency of REQ-019.

Structure
REQ-033 SHALL take the instruction word type, the PC type and the default DATA_W and PC_W from the shared package mips_pkg.
REQ-034 SHALL place the storage array in one sub-module, fetch_queue_mem: synchronous write, asynchronous read, DEPTH x (DATA_W+PC_W).
REQ-035 SHALL implement the pointer, count and handshake control in fetch_queue itself.

Verification
REQ-036 Bench SHALL cover: reset, then push 0x20080005/pc4 0x4 with pop_ready=0 -> pop_valid=1 after one edge, count=1, head=0x20080005.
REQ-037 Bench SHALL cover: fill 4 entries with pop_ready=0 -> push_ready=0, count=4; a fifth push is ignored; popping 4 returns the entries in order.
REQ-038 Bench SHALL cover: 10 back-to-back push+pop at DEPTH=4 across the pointer wrap -> count constant, output sequence equals input sequence.
REQ-039 Bench SHALL cover: count=3, assert flush with push_valid=1 and pop_ready=1 -> head popped that cycle, count=0 next cycle, pushed entry absent.
REQ-040 Bench SHALL cover: rst_n low mid-stream at count=2 -> count=0 and pop_valid=0 with no clock edge.
REQ-041 Bench SHALL cover: with FETCH_QUEUE_BYPASS_EN, empty queue, push 0x8C090000 with pop_ready=1 -> same-cycle pop_valid=1, pop_instr=0x8C090000, count stays 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and default widths used by the fetch path.
package mips_pkg;

   localparam int MIPS_DATA_W = 32;
   localparam int MIPS_PC_W   = 32;

   typedef logic [MIPS_DATA_W-1:0] instr_t;
   typedef logic [MIPS_PC_W-1:0]   pc_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Push/pop handshake bundle between instruction memory, fetch queue and IF/ID.
interface fetch_queue_if
   import mips_pkg::*;
#(
   parameter int DATA_W = MIPS_DATA_W,
   parameter int PC_W   = MIPS_PC_W
) ();

   logic              push_valid;
   logic              push_ready;
   logic [DATA_W-1:0] push_instr;
   logic [PC_W-1:0]   push_pc4;
   logic              pop_valid;
   logic              pop_ready;
   logic [DATA_W-1:0] pop_instr;
   logic [PC_W-1:0]   pop_pc4;

   modport master (
      output push_valid, push_instr, push_pc4, pop_ready,
      input  push_ready, pop_valid, pop_instr, pop_pc4
   );

   modport slave (
      input  push_valid, push_instr, push_pc4, pop_ready,
      output push_ready, pop_valid, pop_instr, pop_pc4
   );

endinterface

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: synchronous write, asynchronous read, DEPTH x WIDTH.
module fetch_queue_mem #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between imem and IF/ID with flush on redirect.
// Optional same-cycle bypass on an empty queue: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
   import mips_pkg::*;
#(
   parameter int DATA_W = MIPS_DATA_W,
   parameter int PC_W   = MIPS_PC_W,
   parameter int DEPTH  = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH+1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   fetch_queue_if.slave       q,
   output logic [CNT_W-1:0]   count
);

   localparam int W = DATA_W + PC_W;

   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0] count_q;
   logic             not_empty;
   logic             pop_mem;
   logic             wr_en;
   logic [W-1:0]     rdata;

   assign not_empty = (count_q != '0);
   // Ready comes from the registered count only, so a full queue never passes through.
   assign q.push_ready = (count_q < CNT_W'(DEPTH));
   assign pop_mem      = not_empty && q.pop_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
   logic byp_avail;
   assign byp_avail = !not_empty && q.push_valid && !flush;
   // A bypassed entry consumed this cycle is never written.
   assign wr_en = q.push_valid && q.push_ready && !flush && !(byp_avail && q.pop_ready);
`else
   assign wr_en = q.push_valid && q.push_ready && !flush;
`endif

   fetch_queue_mem #(
      .DEPTH (DEPTH),
      .WIDTH (W)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata ({q.push_instr, q.push_pc4}),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   always_comb begin
      q.pop_valid = not_empty;
      q.pop_instr = '0;
      q.pop_pc4   = '0;
      if (not_empty) begin
         q.pop_instr = rdata[W-1:PC_W];
         q.pop_pc4   = rdata[PC_W-1:0];
      end
`ifdef FETCH_QUEUE_BYPASS_EN
      if (byp_avail) begin
         q.pop_valid = 1'b1;
         q.pop_instr = q.push_instr;
         q.pop_pc4   = q.push_pc4;
      end
`endif
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (pop_mem) rd_ptr <= rd_ptr + PTR_W'(1);
         if (wr_en)   wr_ptr <= wr_ptr + PTR_W'(1);
         case ({wr_en, pop_mem})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue at DEPTH=4 (bypass checks follow FETCH_QUEUE_BYPASS_EN).
module tb_fetch_queue;
   import mips_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic [2:0] count;
   int         n_chk  = 0;
   int         n_pass = 0;

   fetch_queue_if #(.DATA_W(32), .PC_W(32)) bus ();

   fetch_queue #(.DATA_W(32), .PC_W(32), .DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .q     (bus.slave),
      .count (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic pv, input instr_t ins, input pc_t pc, input logic pr, input logic fl);
      bus.push_valid = pv;
      bus.push_instr = ins;
      bus.push_pc4   = pc;
      bus.pop_ready  = pr;
      flush          = fl;
   endtask

   instr_t fill_i [4] = '{32'h20080005, 32'h00000011, 32'h00000022, 32'h00000033};
   pc_t    fill_p [4] = '{32'h4, 32'h8, 32'hC, 32'h10};

   initial begin
      rst_n = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      #2;
      check("rst_count", count, 0);
      check("rst_push_ready", bus.push_ready, 1);
      check("rst_pop_valid", bus.pop_valid, 0);
      check("rst_pop_instr", bus.pop_instr, 0);
      check("rst_pop_pc4", bus.pop_pc4, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // First push with IF/ID stalled: one-cycle latency
      drive(1'b1, 32'h20080005, 32'h4, 1'b0, 1'b0);
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      check("first_byp_valid", bus.pop_valid, 1);
      check("first_byp_instr", bus.pop_instr, 32'h20080005);
`else
      check("first_same_cycle_valid", bus.pop_valid, 0);
`endif
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      check("first_pop_valid", bus.pop_valid, 1);
      check("first_count", count, 1);
      check("first_head", bus.pop_instr, 32'h20080005);
      check("first_pc4", bus.pop_pc4, 32'h4);

      // Fill to DEPTH, then a fifth push must be ignored
      for (int i = 1; i < 4; i++) begin
         drive(1'b1, fill_i[i], fill_p[i], 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      check("full_count", count, 4);
      check("full_push_ready", bus.push_ready, 0);
      drive(1'b1, 32'h00000099, 32'h99, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      check("full_ignore_count", count, 4);
      check("stall_head_stable", bus.pop_instr, 32'h20080005);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, '0, '0, 1'b1, 1'b0);
         #1;
         check("drain_instr", bus.pop_instr, fill_i[i]);
         check("drain_pc4", bus.pop_pc4, fill_p[i]);
         tick();
      end
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      check("drain_count", count, 0);
      check("drain_pop_valid", bus.pop_valid, 0);
      check("drain_ignore_pop", bus.pop_instr, 0);

      // Preload two, then 10 simultaneous push+pop across the wrap
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'hA000_0000 + i, 32'h100 + 4 * i, 1'b0, 1'b0);
         tick();
      end
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 32'hA000_0000 + i + 2, 32'h100 + 4 * (i + 2), 1'b1, 1'b0);
         #1;
         check("wrap_instr", bus.pop_instr, 32'hA000_0000 + i);
         check("wrap_pc4", bus.pop_pc4, 32'h100 + 4 * i);
         tick();
         check("wrap_count", count, 2);
      end

      // Reach count=3, then flush with a concurrent push and pop
      drive(1'b1, 32'hA000_000C, 32'h130, 1'b0, 1'b0);
      tick();
      check("preflush_count", count, 3);
      drive(1'b1, 32'hDEADBEEF, 32'h999, 1'b1, 1'b1);
      #1;
      check("flush_pop_valid", bus.pop_valid, 1);
      check("flush_head", bus.pop_instr, 32'hA000_000A);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      check("postflush_count", count, 0);
      check("postflush_pop_valid", bus.pop_valid, 0);
      drive(1'b1, 32'hB0000000, 32'h200, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'hB0000001, 32'h204, 1'b0, 1'b0);
      #1;
      check("postflush_head", bus.pop_instr, 32'hB0000000);
      check("postflush_count1", count, 1);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      check("prereset_count", count, 2);

      // Asynchronous reset mid-stream, no clock edge in between
      rst_n = 1'b0;
      #1;
      check("async_rst_count", count, 0);
      check("async_rst_pop_valid", bus.pop_valid, 0);
      check("async_rst_push_ready", bus.push_ready, 1);
      check("async_rst_pop_instr", bus.pop_instr, 0);
      tick();
      rst_n = 1'b1;

      // Empty queue, consumer ready
      drive(1'b1, 32'h8C090000, 32'h300, 1'b1, 1'b0);
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      check("byp_pop_valid", bus.pop_valid, 1);
      check("byp_pop_instr", bus.pop_instr, 32'h8C090000);
      check("byp_pop_pc4", bus.pop_pc4, 32'h300);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      check("byp_count", count, 0);
`else
      check("nobyp_pop_valid", bus.pop_valid, 0);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      check("nobyp_count", count, 1);
      check("nobyp_head", bus.pop_instr, 32'h8C090000);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
